// File: rtl/ahb_bram_ctrl_pkg.sv
// Shared encodings for the AHB-Lite block RAM controller: bus field values
// and the controller FSM state type.
package ahb_bram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_ERR1    = 3'd3,
        ST_ERR2    = 3'd4
    } ahb_state_e;

endpackage

// File: rtl/ahb_bram_ctrl_if.sv
// AHB-Lite signal bundle between a bus master/interconnect and the block RAM
// controller; clock and reset are carried as plain ports.
interface ahb_bram_ctrl_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport slave (
        input  HSEL,
        input  HADDR,
        input  HTRANS,
        input  HWRITE,
        input  HSIZE,
        input  HWDATA,
        input  HREADY,
        output HRDATA,
        output HREADYOUT,
        output HRESP
    );

    modport master (
        output HSEL,
        output HADDR,
        output HTRANS,
        output HWRITE,
        output HSIZE,
        output HWDATA,
        input  HREADY,
        input  HRDATA,
        input  HREADYOUT,
        input  HRESP
    );

endinterface

// File: rtl/ahb_bram_ctrl_lane.sv
// Byte-lane decoder: turns transfer size and low address bits into the
// RAM byte-enable mask and flags misaligned or oversized transfers.
module ahb_lane_decode
    import ahb_bram_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] mask,
    output logic       illegal
);

    always_comb begin
        mask    = 4'b0000;
        illegal = 1'b0;
        case (hsize)
            HSIZE_BYTE: begin
                mask = 4'b0001 << addr_lo;
            end
            HSIZE_HALF: begin
                mask    = addr_lo[1] ? 4'b1100 : 4'b0011;
                illegal = addr_lo[0];
            end
            HSIZE_WORD: begin
                mask    = 4'b1111;
                illegal = (addr_lo != 2'b00);
            end
            default: begin
                // Anything wider than a word cannot fit the 32-bit RAM port.
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave bridging a Cortex-M0 bus to a 32-bit dual-port block RAM:
// zero-wait reads/writes, write-to-read forwarding, two-cycle ERROR response.
module ahb_bram_ctrl
    import ahb_bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahb_bram_ctrl_if.slave        ahb,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [31:0]           ram_dina,
    output logic [3:0]            ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [31:0]           ram_doutb
);

    ahb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [3:0]             mask_q, mask_d;
    logic                   fwd_valid_q, fwd_valid_d;
    logic [ADDR_WIDTH-1:0]  fwd_addr_q, fwd_addr_d;
    logic [3:0]             fwd_mask_q, fwd_mask_d;
    logic [31:0]            fwd_data_q, fwd_data_d;

    logic [ADDR_WIDTH-1:0]  haddr_word;
    logic [3:0]             lane_mask;
    logic                   lane_illegal;
    logic                   accept;
    logic                   fwd_hit;
    ahb_state_e             out_state;
    logic [31:0]            hrdata;
    logic                   hreadyout;
    logic                   hresp;
    logic                   unused_addr_bits;

    assign haddr_word       = ahb.HADDR[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{ahb.HTRANS[0], ahb.HADDR[31:ADDR_WIDTH+2]};

    ahb_lane_decode u_lane_decode (
        .hsize   (ahb.HSIZE),
        .addr_lo (ahb.HADDR[1:0]),
        .mask    (lane_mask),
        .illegal (lane_illegal)
    );

    // ERR1 is the only stalled state, so no new address phase is taken there.
    assign accept = ahb.HSEL && ahb.HTRANS[1] && ahb.HREADY && (state_q != ST_ERR1);

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        mask_d    = mask_q;
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (accept) begin
            wr_addr_d = haddr_word;
            rd_addr_d = haddr_word;
            mask_d    = lane_mask;
            if (lane_illegal) begin
                state_d = ST_ERR1;
            end else if (ahb.HWRITE) begin
                state_d = ST_WR_DATA;
            end else begin
                state_d = ST_RD_DATA;
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    // The RAM is read-first, so a read right behind a write to the same word
    // sees stale lanes; remember the last write so those lanes can be patched.
    always_comb begin
        fwd_valid_d = (state_q == ST_WR_DATA);
        fwd_addr_d  = fwd_addr_q;
        fwd_mask_d  = fwd_mask_q;
        fwd_data_d  = fwd_data_q;
        if (state_q == ST_WR_DATA) begin
            fwd_addr_d = wr_addr_q;
            fwd_mask_d = mask_q;
            fwd_data_d = ahb.HWDATA;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            fwd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fwd_valid_q <= fwd_valid_d;
        end
    end

    always_ff @(posedge HCLK) begin
        wr_addr_q  <= wr_addr_d;
        rd_addr_q  <= rd_addr_d;
        mask_q     <= mask_d;
        fwd_addr_q <= fwd_addr_d;
        fwd_mask_q <= fwd_mask_d;
        fwd_data_q <= fwd_data_d;
    end

    // While reset is high every output looks like IDLE, which also kills a
    // write whose data phase coincides with the reset cycle.
    assign out_state = HRESET ? ST_IDLE : state_q;
    assign fwd_hit   = fwd_valid_q && (fwd_addr_q == rd_addr_q);

    always_comb begin
        hrdata    = 32'h0000_0000;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        ram_addra = '0;
        ram_dina  = 32'h0000_0000;
        ram_wea   = 4'b0000;
        case (out_state)
            ST_WR_DATA: begin
                ram_addra = wr_addr_q;
                ram_dina  = ahb.HWDATA;
                ram_wea   = mask_q;
            end
            ST_RD_DATA: begin
                for (int i = 0; i < 4; i++) begin
                    hrdata[8*i +: 8] = (fwd_hit && fwd_mask_q[i]) ? fwd_data_q[8*i +: 8]
                                                                  : ram_doutb[8*i +: 8];
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
            end
            ST_ERR2: begin
                hresp = HRESP_ERROR;
            end
            default: begin
            end
        endcase
    end

    assign ram_addrb     = haddr_word;
    assign ahb.HRDATA    = hrdata;
    assign ahb.HREADYOUT = hreadyout;
    assign ahb.HRESP     = hresp;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Self-checking bench for ahb_bram_ctrl: directed scenarios plus randomized
// back-to-back traffic checked against a byte-level memory reference model.
module tb_ahb_bram_ctrl;
    import ahb_bram_pkg::*;

    localparam int AW        = 10;
    localparam int RAM_WORDS = 1 << AW;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [AW-1:0] ram_addra;
    logic [31:0]   ram_dina;
    logic [3:0]    ram_wea;
    logic [AW-1:0] ram_addrb;
    logic [31:0]   ram_doutb;
    logic          ram_init;

    logic [31:0]   ram_mem [RAM_WORDS];
    logic [31:0]   ref_mem [RAM_WORDS];

    int checks   = 0;
    int failures = 0;

    ahb_bram_ctrl_if bus ();
    assign bus.HREADY = bus.HREADYOUT;

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .ahb       (bus),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_wea   (ram_wea),
        .ram_addrb (ram_addrb),
        .ram_doutb (ram_doutb)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Read-first synchronous dual-port RAM.
    always @(posedge HCLK) begin
        if (ram_init) begin
            for (int i = 0; i < RAM_WORDS; i++) ram_mem[i] <= init_word(i);
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_wea[b]) ram_mem[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
        end
        ram_doutb <= ram_mem[ram_addrb];
    end

    function automatic int widx(input logic [31:0] addr);
        return int'((addr >> 2) % RAM_WORDS);
    endfunction

    // Architectural effect of a legal write: the addressed bytes take their lanes of data.
    function automatic void ref_write(input logic [31:0] addr, input logic [2:0] size,
                                      input logic [31:0] data);
        int idx   = widx(addr);
        int first = int'(addr % 4);
        int nb    = 1 << size;
        for (int b = first; b < first + nb; b++) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
    endfunction

    task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        bus.HSEL   = sel;
        bus.HTRANS = trans;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        bus.HADDR  = addr;
        bus.HWDATA = wdata;
    endtask

    task automatic idle_addr(input logic [31:0] wdata);
        drive(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0, wdata);
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0000_0008, 32'h1234_5678);
        for (int c = 0; c < 2; c++) begin
            @(negedge HCLK);
            checks++; if (bus.HREADYOUT !== 1'b1) begin failures++; $display("FAIL reset_hreadyout got=%b exp=1", bus.HREADYOUT); end
            checks++; if (bus.HRESP !== 1'b0) begin failures++; $display("FAIL reset_hresp got=%b exp=0", bus.HRESP); end
            checks++; if (bus.HRDATA !== 32'h0) begin failures++; $display("FAIL reset_hrdata got=%h exp=0", bus.HRDATA); end
            checks++; if (ram_wea !== 4'h0) begin failures++; $display("FAIL reset_wea got=%h exp=0", ram_wea); end
            checks++; if (ram_addra !== '0 || ram_dina !== 32'h0) begin
                failures++; $display("FAIL reset_addra_dina got=%h/%h exp=0/0", ram_addra, ram_dina); end
            next_cycle();
        end
        idle_addr(32'h0);
        HRESET = 1'b0;
        next_cycle();
    endtask

    task automatic test_word_write_read();
        drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0000_0010, 32'h0);
        @(negedge HCLK);
        checks++; if (bus.HREADYOUT !== 1'b1) begin failures++; $display("FAIL ww_addr_ready got=%b exp=1", bus.HREADYOUT); end
        next_cycle();
        idle_addr(32'hDEAD_BEEF);
        ref_write(32'h0000_0010, HSIZE_WORD, 32'hDEAD_BEEF);
        @(negedge HCLK);
        checks++; if (ram_wea !== 4'hF) begin failures++; $display("FAIL ww_wea got=%h exp=f", ram_wea); end
        checks++; if (ram_addra !== AW'(4)) begin failures++; $display("FAIL ww_addra got=%0d exp=4", ram_addra); end
        checks++; if (ram_dina !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ww_dina got=%h exp=deadbeef", ram_dina); end
        checks++; if (bus.HREADYOUT !== 1'b1) begin failures++; $display("FAIL ww_data_ready got=%b exp=1", bus.HREADYOUT); end
        next_cycle();
        idle_addr(32'h0);
        @(negedge HCLK);
        checks++; if (ram_wea !== 4'h0) begin failures++; $display("FAIL ww_idle_wea got=%h exp=0", ram_wea); end
        next_cycle();
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0010, 32'h0);
        @(negedge HCLK);
        checks++; if (ram_addrb !== AW'(4)) begin failures++; $display("FAIL wr_addrb got=%0d exp=4", ram_addrb); end
        next_cycle();
        idle_addr(32'h0);
        @(negedge HCLK);
        checks++; if (bus.HRDATA !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_hrdata got=%h exp=deadbeef", bus.HRDATA); end
        checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin
            failures++; $display("FAIL wr_resp got=%b/%b exp=1/0", bus.HREADYOUT, bus.HRESP); end
        next_cycle();
    endtask

    task automatic test_byte_writes();
        logic [7:0] bytes [4];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        for (int i = 0; i <= 4; i++) begin
            logic [31:0] wd;
            wd = (i > 0) ? {4{bytes[i-1]}} : 32'h0;
            if (i < 4) drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h20 + 32'(i), wd);
            else       drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, wd);
            if (i < 4) ref_write(32'h20 + 32'(i), HSIZE_BYTE, {4{bytes[i]}});
            @(negedge HCLK);
            if (i > 0) begin
                checks++; if (ram_wea !== 4'(1 << (i - 1))) begin
                    failures++; $display("FAIL byte_wea[%0d] got=%h exp=%h", i - 1, ram_wea, 4'(1 << (i - 1))); end
            end
            next_cycle();
        end
        idle_addr(32'h0);
        @(negedge HCLK);
        checks++; if (bus.HRDATA !== 32'h4433_2211) begin failures++; $display("FAIL byte_readback got=%h exp=44332211", bus.HRDATA); end
        next_cycle();
    endtask

    task automatic test_forward();
        drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h30, 32'h0);
        ref_write(32'h30, HSIZE_WORD, 32'hAAAA_AAAA);
        next_cycle();
        drive(1'b1, HTRANS_SEQ, 1'b1, HSIZE_HALF, 32'h32, 32'hAAAA_AAAA);
        ref_write(32'h32, HSIZE_HALF, 32'h5555_1234);
        next_cycle();
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h30, 32'h5555_1234);
        @(negedge HCLK);
        checks++; if (ram_wea !== 4'b1100) begin failures++; $display("FAIL fwd_half_wea got=%h exp=c", ram_wea); end
        next_cycle();
        idle_addr(32'h0);
        @(negedge HCLK);
        checks++; if (bus.HRDATA !== 32'h5555_AAAA) begin failures++; $display("FAIL fwd_hrdata got=%h exp=5555aaaa", bus.HRDATA); end
        next_cycle();
    endtask

    task automatic test_misaligned();
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h05, 32'h0);
        next_cycle();
        idle_addr(32'h0);
        @(negedge HCLK);
        checks++; if (bus.HREADYOUT !== 1'b0 || bus.HRESP !== 1'b1) begin
            failures++; $display("FAIL mis_err1 got=%b/%b exp=0/1", bus.HREADYOUT, bus.HRESP); end
        checks++; if (ram_wea !== 4'h0) begin failures++; $display("FAIL mis_err1_wea got=%h exp=0", ram_wea); end
        next_cycle();
        @(negedge HCLK);
        checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b1) begin
            failures++; $display("FAIL mis_err2 got=%b/%b exp=1/1", bus.HREADYOUT, bus.HRESP); end
        next_cycle();
        @(negedge HCLK);
        checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin
            failures++; $display("FAIL mis_after got=%b/%b exp=1/0", bus.HREADYOUT, bus.HRESP); end
        next_cycle();
    endtask

    task automatic test_oversize();
        drive(1'b1, HTRANS_NONSEQ, 1'b1, 3'd3, 32'h44, 32'h0);
        next_cycle();
        idle_addr(32'hFFFF_FFFF);
        @(negedge HCLK);
        checks++; if (bus.HREADYOUT !== 1'b0 || bus.HRESP !== 1'b1) begin
            failures++; $display("FAIL big_err1 got=%b/%b exp=0/1", bus.HREADYOUT, bus.HRESP); end
        checks++; if (ram_wea !== 4'h0) begin failures++; $display("FAIL big_err1_wea got=%h exp=0", ram_wea); end
        next_cycle();
        @(negedge HCLK);
        checks++; if (ram_wea !== 4'h0 || bus.HRESP !== 1'b1) begin
            failures++; $display("FAIL big_err2 got=wea %h resp %b exp=wea 0 resp 1", ram_wea, bus.HRESP); end
        next_cycle();
        @(negedge HCLK);
        checks++; if (ram_mem[17] !== ref_mem[17]) begin failures++; $display("FAIL big_mem17 got=%h exp=%h", ram_mem[17], ref_mem[17]); end
        next_cycle();
    endtask

    task automatic test_reset_mid_write();
        drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h50, 32'h0);
        next_cycle();
        HRESET = 1'b1;
        idle_addr(32'hCAFE_F00D);
        @(negedge HCLK);
        checks++; if (ram_wea !== 4'h0) begin failures++; $display("FAIL rstw_wea got=%h exp=0", ram_wea); end
        checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0 || bus.HRDATA !== 32'h0) begin
            failures++; $display("FAIL rstw_bus got=%b/%b/%h exp=1/0/0", bus.HREADYOUT, bus.HRESP, bus.HRDATA); end
        checks++; if (ram_addra !== '0 || ram_dina !== 32'h0) begin
            failures++; $display("FAIL rstw_ram got=%h/%h exp=0/0", ram_addra, ram_dina); end
        next_cycle();
        HRESET = 1'b0;
        idle_addr(32'h0);
        @(negedge HCLK);
        checks++; if (ram_mem[20] !== ref_mem[20]) begin failures++; $display("FAIL rstw_mem got=%h exp=%h", ram_mem[20], ref_mem[20]); end
        next_cycle();
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h50, 32'h0);
        next_cycle();
        idle_addr(32'h0);
        @(negedge HCLK);
        checks++; if (bus.HRDATA !== ref_mem[20]) begin failures++; $display("FAIL rstw_read got=%h exp=%h", bus.HRDATA, ref_mem[20]); end
        next_cycle();
    endtask

    // Random zero-wait traffic over a few aliased words so collisions are frequent.
    task automatic test_back_to_back();
        int            n = 300;
        int            p_kind = 0;
        logic [3:0]    p_mask = 4'h0;
        logic [AW-1:0] p_idx = '0;
        logic [31:0]   p_wdata = 32'h0;
        logic [31:0]   p_exp = 32'h0;
        for (int i = 0; i <= n; i++) begin
            int          kind, off, nb;
            logic [2:0]  size;
            logic [31:0] addr, wdata, exp;
            logic [3:0]  mask;
            kind  = (i == n) ? 0 : int'($urandom_range(0, 4));
            size  = 3'($urandom_range(0, 2));
            off   = (size == HSIZE_BYTE) ? int'($urandom_range(0, 3)) :
                    (size == HSIZE_HALF) ? 2 * int'($urandom_range(0, 1)) : 0;
            addr  = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 7)) << 2) | 32'(off);
            wdata = $urandom;
            nb    = 1 << size;
            mask  = 4'(((1 << nb) - 1) << off);
            exp   = 32'h0;
            if (kind == 0) begin
                case ($urandom_range(0, 2))
                    0: drive(1'b0, HTRANS_NONSEQ, 1'b1, size, addr, 32'h0);
                    1: drive(1'b1, HTRANS_IDLE, 1'b1, size, addr, 32'h0);
                    default: drive(1'b1, HTRANS_BUSY, 1'b0, size, addr, 32'h0);
                endcase
            end else if (kind <= 2) begin
                drive(1'b1, ($urandom_range(0, 1) != 0) ? HTRANS_SEQ : HTRANS_NONSEQ, 1'b1, size, addr, 32'h0);
                ref_write(addr, size, wdata);
            end else begin
                drive(1'b1, HTRANS_NONSEQ, 1'b0, size, addr, 32'h0);
                exp = ref_mem[widx(addr)];
            end
            bus.HWDATA = (p_kind >= 1 && p_kind <= 2) ? p_wdata : $urandom;
            @(negedge HCLK);
            checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin
                failures++; $display("FAIL b2b_resp[%0d] got=%b/%b exp=1/0", i, bus.HREADYOUT, bus.HRESP); end
            if (p_kind >= 1 && p_kind <= 2) begin
                checks++; if (ram_wea !== p_mask || ram_addra !== p_idx || ram_dina !== p_wdata) begin
                    failures++; $display("FAIL b2b_write[%0d] got=%h@%0d:%h exp=%h@%0d:%h",
                                         i, ram_wea, ram_addra, ram_dina, p_mask, p_idx, p_wdata); end
            end else if (p_kind >= 3) begin
                checks++; if (bus.HRDATA !== p_exp) begin
                    failures++; $display("FAIL b2b_read[%0d] got=%h exp=%h", i, bus.HRDATA, p_exp); end
            end else begin
                checks++; if (ram_wea !== 4'h0 || bus.HRDATA !== 32'h0) begin
                    failures++; $display("FAIL b2b_noop[%0d] got=%h/%h exp=0/0", i, ram_wea, bus.HRDATA); end
            end
            next_cycle();
            p_kind  = kind;
            p_mask  = mask;
            p_idx   = AW'(widx(addr));
            p_wdata = wdata;
            p_exp   = exp;
        end
        idle_addr(32'h0);
        next_cycle();
    endtask

    initial begin
        HRESET   = 1'b1;
        ram_init = 1'b1;
        idle_addr(32'h0);
        for (int i = 0; i < RAM_WORDS; i++) ref_mem[i] = init_word(i);
        repeat (2) @(posedge HCLK);
        #1;
        ram_init = 1'b0;
        test_reset();
        test_word_write_read();
        test_byte_writes();
        test_forward();
        test_misaligned();
        test_oversize();
        test_reset_mid_write();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ahb_bram_ctrl.md
Name: ahb_bram_ctrl

Overview:
- AHB-Lite slave that bridges the Cortex-M0 bus to the 32-bit dual-port program/data block RAM.
- Drives the RAM write port (addr/dina/byte-wea) and read port (addrb), and returns doutb as HRDATA.
- Zero-wait-state for legal transfers, with write-to-read forwarding. Misaligned or oversized transfers get a two-cycle ERROR response.

Parameters:
ADDR_WIDTH, 14, word-address width of the attached RAM (RAM depth = 2**ADDR_WIDTH words, byte span = 2**(ADDR_WIDTH+2)).

Ports:
HCLK  in  1  the single clock; also drives the RAM's clka.
HRESET  in  1  synchronous, active-high reset.
HSEL  in  1  slave select.
HADDR  in  32  byte address.
HTRANS  in  2  transfer type; only NONSEQ (2'b10) and SEQ (2'b11) are valid.
HWRITE  in  1  1 = write.
HSIZE  in  3  transfer size: 0 = byte, 1 = half, 2 = word.
HWDATA  in  32  write data, valid in the data phase.
HREADY  in  1  bus-level ready.
HRDATA  out  32  read data.
HREADYOUT  out  1  slave ready.
HRESP  out  1  0 = OKAY, 1 = ERROR.
ram_addra  out  ADDR_WIDTH  RAM write word address.
ram_dina  out  32  RAM write data.
ram_wea  out  4  RAM byte write enables.
ram_addrb  out  ADDR_WIDTH  RAM read word address.
ram_doutb  in  32  RAM registered read data (one-cycle latency).

Behaviour:
- Transfer acceptance: a transfer is accepted at a rising edge when HSEL & HTRANS[1] & HREADY.
- Address decode: word index = HADDR[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias.
- Lane mask (combinational, from HSIZE and HADDR[1:0]):
  - byte: 1 << HADDR[1:0].
  - half: HADDR[1] ? 4'b1100 : 4'b0011.
  - word: 4'b1111.
- Illegal transfers: half with HADDR[0]=1, word with HADDR[1:0]!=0, or HSIZE>=3.
- FSM states: IDLE, WR_DATA, RD_DATA, ERR1, ERR2. State is registered; reset enters IDLE.
- From any state where HREADYOUT=1, an accepted transfer moves to:
  - ERR1 if illegal;
  - otherwise WR_DATA or RD_DATA per HWRITE;
  - IDLE if no transfer is accepted.
- ERR1 -> ERR2 unconditionally. ERR2 behaves like IDLE for the next acceptance.
- Outputs per state:
  - HREADYOUT = 0 only in ERR1.
  - HRESP = 1 in ERR1 and ERR2.
  - Illegal transfers never assert ram_wea.
- Address-phase registers (wr_addr_q, mask_q) are captured on acceptance.
- Write path:
  - In WR_DATA: ram_addra = wr_addr_q, ram_wea = mask_q, ram_dina = HWDATA.
  - RAM writes at the edge ending the data phase.
  - ram_wea = 0 in all other states.
- Read path:
  - ram_addrb = HADDR word index, combinational.
  - The RAM samples it at the acceptance edge, and ram_doutb is valid in RD_DATA.
  - HRDATA is the full word; the CPU selects lanes.
- Forwarding:
  - On the edge ending WR_DATA, register fwd_valid = 1, fwd_addr, fwd_mask and fwd_data = HWDATA.
  - Any other edge clears fwd_valid.
  - In RD_DATA, if fwd_valid && fwd_addr == rd_addr_q, HRDATA lanes in fwd_mask come from fwd_data and the rest from ram_doutb.
  - This covers the write-then-read collision where the RAM returns pre-write data.
- Reset values:
  - HREADYOUT = 1, HRESP = 0, HRDATA = 0 (forced to 0 outside RD_DATA), ram_wea = 0.
  - ram_addra = 0; ram_dina follows HWDATA in WR_DATA and is 0 elsewhere.
  - fwd_valid = 0.
- Reset mid-write: HRESET during WR_DATA suppresses the write that cycle (ram_wea gated by ~HRESET).
- IDLE/BUSY transfers and HSEL=0 are accepted as no-ops with an OKAY response.
- Back-to-back transfers: write->write, read->write and write->read all run at zero wait. The address phase of transfer N+1 overlaps the data phase of transfer N.

Decomposition:
- Package ahb_bram_pkg holds:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ);
  - HSIZE encodings (BYTE, HALF, WORD);
  - HRESP constants;
  - the FSM state enum.
- Sub-module ahb_lane_decode is combinational: (HSIZE, HADDR[1:0]) -> mask[3:0], illegal.

Test Plan:
- Word write 0x0000_0010 data 0xDEADBEEF, then idle, then read 0x10 -> ram_wea=4'hF on ram_addra=4; HRDATA=0xDEADBEEF; HREADYOUT stays 1 throughout.
- Byte writes 0x11/0x22/0x33/0x44 to 0x20..0x23, then word read 0x20 -> wea sequence 1, 2, 4, 8; HRDATA=0x44332211.
- Word write 0x30 = 0xAAAAAAAA, then immediately a halfword write 0x32 = 0x5555xxxx followed back-to-back by word read 0x30 -> HRDATA=0x5555AAAA via forwarding.
- Word read at 0x05 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); no RAM write.
- Word write 0x44 with HSIZE=3 -> ERROR response; ram_wea stays 0 and memory at index 17 is unchanged.
- HRESET asserted during WR_DATA of word write 0x50 -> ram_wea=0 that cycle; all outputs at reset values; a read of 0x50 returns the prior contents.
